// File: rtl/shift_pkg.sv
// Shared constants for the shift datapath blocks: FSM state codes, shift
// direction and shift kind, used by the normalizer and the barrel shifter.
package shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic SHIFT_LOGIC = 1'b0;
  localparam logic SHIFT_ARITH = 1'b1;

endpackage

// File: rtl/seq_normalizer.sv
// Multi-cycle left normalizer: shifts a word left one bit per cycle until its MSB
// is set, reporting the shift count so that data_in << shift_amount == data_out.
module seq_normalizer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SAW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [SAW-1:0]   shift_amount,
  output logic             zero
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : gen_width_check
    $error("seq_normalizer: WIDTH must be a power of 2 and >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SAW-1:0]   cnt_q, cnt_d;
  logic             zero_q, zero_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = data_in;
          cnt_d   = '0;
          zero_d  = (data_in == '0);
          state_d = StShift;
        end
      end
      StShift: begin
        // A nonzero word reaches MSB=1 within WIDTH-1 shifts, so cnt cannot wrap.
        if (work_q == '0 || work_q[WIDTH-1]) begin
          state_d = StDone;
        end else begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + SAW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs come straight from registers; work is frozen outside SHIFT.
  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign data_out     = work_q;
  assign shift_amount = cnt_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed self-checking bench for seq_normalizer (WIDTH=8): latency, boundary
// words, backpressure, mid-operation reset and a pseudo-random inverse check.
module tb_seq_normalizer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic [2:0] shift_amount;
  logic       zero;

  int checks;
  int errors;

  seq_normalizer #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .shift_amount (shift_amount),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and complete the accept edge; waits (bounded) for in_ready.
  task automatic accept_word(input logic [7:0] d, output bit ok);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    ok = in_ready;
    in_valid = 1'b1;
    data_in  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (capped at 20).
  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  function automatic int lead_zeros(input logic [7:0] d);
    int n;
    n = 0;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) return n;
      n++;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    checks++;
    if (data_out !== 8'h00 || shift_amount !== 3'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: data_out=%h sa=%0d zero=%b required 00 0 0",
               data_out, shift_amount, zero);
    end
  endtask

  task automatic test_pattern();
    bit ok;
    int e;
    out_ready = 1'b1;
    accept_word(8'b0001_0110, ok);
    wait_done(e);
    checks++;
    if (!ok || e != 4) begin
      errors++;
      $display("FAIL pat_latency: edges=%0d accepted=%0d required 4 1", e, ok);
    end
    checks++;
    if (data_out !== 8'b1011_0000 || shift_amount !== 3'd3 || zero !== 1'b0) begin
      errors++;
      $display("FAIL pat_result: data_out=%h sa=%0d zero=%b required b0 3 0",
               data_out, shift_amount, zero);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pat_one_done: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_boundaries();
    bit ok;
    int e;
    out_ready = 1'b1;
    accept_word(8'h80, ok);
    wait_done(e);
    checks++;
    if (e != 1 || data_out !== 8'h80 || shift_amount !== 3'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL msb_set: edges=%0d data_out=%h sa=%0d zero=%b required 1 80 0 0",
               e, data_out, shift_amount, zero);
    end
    tick();
    accept_word(8'h01, ok);
    wait_done(e);
    checks++;
    if (e != 8 || data_out !== 8'h80 || shift_amount !== 3'd7 || zero !== 1'b0) begin
      errors++;
      $display("FAIL lsb_only: edges=%0d data_out=%h sa=%0d zero=%b required 8 80 7 0",
               e, data_out, shift_amount, zero);
    end
    tick();
  endtask

  task automatic test_zero();
    bit ok;
    int e;
    out_ready = 1'b1;
    accept_word(8'h00, ok);
    wait_done(e);
    checks++;
    if (e != 1 || data_out !== 8'h00 || shift_amount !== 3'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL zero_word: edges=%0d data_out=%h sa=%0d zero=%b required 1 00 0 1",
               e, data_out, shift_amount, zero);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int e;
    int bad;
    out_ready = 1'b0;
    accept_word(8'b0001_0110, ok);
    wait_done(e);
    bad = 0;
    in_valid = 1'b1;
    data_in  = 8'hff;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 8'hb0 ||
          shift_amount !== 3'd3 || zero !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: unstable_cycles=%0d data_out=%h sa=%0d required 0 b0 3",
               bad, data_out, shift_amount);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 8'hb0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b data_out=%h required 0 1 b0",
               out_valid, in_ready, data_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    int e;
    int seen;
    out_ready = 1'b1;
    seen = 0;
    accept_word(8'h01, ok);
    for (int i = 0; i < 2; i++) begin
      if (out_valid) seen++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h00 ||
        shift_amount !== 3'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b data_out=%h sa=%0d zero=%b req 1 0 00 0 0",
               in_ready, out_valid, data_out, shift_amount, zero);
    end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_output: out_valid_cycles=%0d required 0", seen);
    end
    accept_word(8'h01, ok);
    wait_done(e);
    checks++;
    if (e != 8 || data_out !== 8'h80 || shift_amount !== 3'd7) begin
      errors++;
      $display("FAIL rst_recover: edges=%0d data_out=%h sa=%0d required 8 80 7",
               e, data_out, shift_amount);
    end
    tick();
  endtask

  task automatic test_random();
    bit ok;
    int e;
    int bad_inv;
    int bad_lat;
    int bad_hold;
    logic [7:0] d;
    logic [7:0] r;
    logic [2:0] s;
    bad_inv  = 0;
    bad_lat  = 0;
    bad_hold = 0;
    for (int n = 0; n < 300; n++) begin
      d = 8'($urandom);
      if (n % 17 == 0) d = 8'h00;
      out_ready = 1'($urandom_range(0, 1));
      accept_word(d, ok);
      wait_done(e);
      if (!ok || e != ((d == 8'h00) ? 1 : lead_zeros(d) + 1)) bad_lat++;
      if (((d << shift_amount) !== data_out) || ((data_out[7] | zero) !== 1'b1) ||
          (zero !== (d == 8'h00)) || (d != 8'h00 && shift_amount != 3'(lead_zeros(d))))
        bad_inv++;
      r = data_out;
      s = shift_amount;
      for (int g = 0; g < 40; g++) begin
        if (out_ready) break;
        tick();
        if (out_valid !== 1'b1 || data_out !== r || shift_amount !== s) bad_hold++;
        out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad_hold++;
    end
    checks++;
    if (bad_lat != 0) begin
      errors++;
      $display("FAIL rand_latency: bad_words=%0d required 0", bad_lat);
    end
    checks++;
    if (bad_inv != 0) begin
      errors++;
      $display("FAIL rand_inverse: bad_words=%0d required 0", bad_inv);
    end
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL rand_handshake: bad_cycles=%0d required 0", bad_hold);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_pattern();
    test_boundaries();
    test_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
